// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts register-addressed ALU commands, reads operands from
// a 32-entry register file (x0 hardwired to zero), drives the external
// combinational ALU, writes the result back and returns a response.
module alu_sequencer #(
  parameter int NREGS = 32,
  parameter int RIDX  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [RIDX-1:0] cmd_rd,
  input  logic [RIDX-1:0] cmd_rs1,
  input  logic [RIDX-1:0] cmd_rs2,
  input  logic            cmd_use_imm,
  input  logic [63:0]     cmd_imm,
  output logic [3:0]      alu_opcode,
  output logic [63:0]     alu_value1,
  output logic [63:0]     alu_value2,
  input  logic [63:0]     alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RIDX-1:0] rsp_rd,
  output logic [63:0]     rsp_data,
  output logic            rsp_err,
  input  logic [RIDX-1:0] dbg_raddr,
  output logic [63:0]     dbg_rdata
);

  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_REM = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [RIDX-1:0] rd_q;
  logic [63:0]     regs [NREGS];
  logic [63:0]     rs1_val;
  logic [63:0]     rs2_val;
  logic            legal;
  logic [63:0]     exec_data;
  logic            exec_err;

  // Operand and debug reads; index 0 always reads as zero.
  assign rs1_val   = (cmd_rs1 == '0) ? 64'd0 : regs[cmd_rs1];
  assign rs2_val   = (cmd_rs2 == '0) ? 64'd0 : regs[cmd_rs2];
  assign dbg_rdata = (dbg_raddr == '0) ? 64'd0 : regs[dbg_raddr];

  // Handshake flags follow the FSM state; ready is forced low while in reset.
  assign cmd_ready = reset_n && (state == IDLE);
  assign rsp_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus result selection, including the divide-by-zero and
  // illegal-opcode overrides of the raw ALU output.
  always_comb begin
    state_next = state;
    legal      = (alu_opcode >= 4'd1) && (alu_opcode <= 4'd9);
    exec_data  = alu_result;
    exec_err   = 1'b0;
    if (!legal) begin
      exec_data = 64'd0;
      exec_err  = 1'b1;
    end else if ((alu_opcode == OP_DIV) && (alu_value2 == 64'd0)) begin
      exec_data = {64{1'b1}};
      exec_err  = 1'b1;
    end else if ((alu_opcode == OP_REM) && (alu_value2 == 64'd0)) begin
      exec_data = alu_value1;
      exec_err  = 1'b1;
    end
    case (state)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch on accept and response latch at the end of EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_opcode <= '0;
      alu_value1 <= '0;
      alu_value2 <= '0;
      rd_q       <= '0;
      rsp_rd     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        alu_opcode <= cmd_op;
        rd_q       <= cmd_rd;
        alu_value1 <= rs1_val;
        alu_value2 <= cmd_use_imm ? cmd_imm : rs2_val;
      end
      if (state == EXEC) begin
        rsp_rd   <= rd_q;
        rsp_data <= exec_data;
        rsp_err  <= exec_err;
      end
    end
  end

  // Register file write-back at the EXEC edge; x0 and illegal ops never write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == EXEC) && legal && (rd_q != '0)) begin
      regs[rd_q] <= exec_data;
    end
  end

endmodule
